// File: rtl/cond_pkg.sv
// Shared definitions for ARM-style condition evaluation: condition encodes and
// the NZCV bit positions used on the flag buses.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_check.sv
// Purely combinational condition evaluator: 4-bit condition field against a
// 4-bit NZCV flag vector. Kept standalone so branch prediction can reuse it.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        condex = 1'b0;
        unique case (cond_e'(cond))
            EQ: condex = z;
            NE: condex = ~z;
            CS: condex = c;
            CC: condex = ~c;
            MI: condex = n;
            PL: condex = ~n;
            VS: condex = v;
            VC: condex = ~v;
            HI: condex = c & ~z;
            LS: condex = ~c | z;
            GE: condex = (n == v);
            LT: condex = (n != v);
            GT: condex = ~z & (n == v);
            LE: condex = z | (n != v);
            AL: condex = 1'b1;
            NV: condex = 1'b0;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Execute-stage condition unit: holds the NZCV flags, evaluates the condition
// field against them and gates the instruction's write enables.
module cond_logic
    import cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       CondExR,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic       condexr_q;
    logic       pass;

    // Decode always reads the stored flags, so a flag-setting instruction
    // sees the pre-update values in its own cycle.
    cond_check u_check (
        .cond   (Cond),
        .flags  (flags_q),
        .condex (CondEx)
    );

    assign pass     = en & CondEx;
    assign PCSrc    = pass & PCS;
    assign RegWrite = pass & RegW & ~NoWrite;
    assign MemWrite = pass & MemW;
    assign Flags    = flags_q;
    assign CondExR  = condexr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= RESET_FLAGS;
            condexr_q <= 1'b0;
        end else if (en) begin
            condexr_q <= CondEx;
            if (CondEx && FlagW[FLAGW_NZ]) begin
                flags_q[FLAG_Z:FLAG_N] <= ALUFlags[FLAG_Z:FLAG_N];
            end
            if (CondEx && FlagW[FLAGW_CV]) begin
                flags_q[FLAG_V:FLAG_C] <= ALUFlags[FLAG_V:FLAG_C];
            end
        end
    end

endmodule
